regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters, e.g. the ALU writeback path (port 0) and the memory-load writeback path (port 1). It uses round-robin arbitration with a req/grant handshake and registered write outputs that drive `Awr`/`Din`/`WrEn` directly. Writes to R0 are granted but never issued. An optional post-reset sequencer writes zero to R1..R31 before arbitration starts.

## Interface
- `DATA_WIDTH`, 32, width of write data.
- `ADDR_WIDTH`, 5, width of register address; register count is 2**ADDR_WIDTH.
- `Clk` input 1 — clock, rising edge.
- `Reset_n` input 1 — reset, asynchronous and active-low.
- `Req0` input 1 — port 0 write request.
- `WrAdr0` input ADDR_WIDTH — port 0 target register.
- `WrData0` input DATA_WIDTH — port 0 write data.
- `Gnt0` output 1 — port 0 grant, one-cycle pulse.
- `Req1`, `WrAdr1`, `WrData1`, `Gnt1` — same as above, for port 1.
- `Awr` output ADDR_WIDTH — register file write address.
- `Din` output DATA_WIDTH — register file write data.
- `WrEn` output 1 — register file write enable.
- `Busy` output 1 — clear sequence in progress; no grants are issued while high.

## Operation
- FSM states:
  - CLEAR: exists only with the macro.
  - RUN: arbitration.
  - Reset enters CLEAR if the macro is defined, otherwise RUN.
- CLEAR behaviour:
  - Counter `cnt` starts at 1.
  - Each edge registers `WrEn=1`, `Awr=cnt`, `Din=0`.
  - If `cnt==2**ADDR_WIDTH-1`, the same edge sets `Busy<=0` and moves to RUN; otherwise `cnt++`.
  - `Req0`/`Req1` are ignored in CLEAR.
- RUN eligibility: port k is eligible at an edge if `Reqk=1` and `Gntk=0` in that cycle. The `Gntk` term suppresses a double grant while the requester is updating.
- RUN arbitration:
  - One eligible port: that port wins.
  - Both eligible: the port not granted last wins.
  - Last-granted pointer resets to 1, so port 0 wins the first tie.
  - The pointer updates only on a grant.
- Winner k, registered on the same edge:
  - `Gntk<=1`
  - `Awr<=WrAdrk`
  - `Din<=WrDatak`
  - `WrEn<=(WrAdrk!=0)`
- R0 writes: grant pulses normally, `WrEn` stays 0, `Awr`/`Din` still load.
- No winner: `Gnt0/Gnt1/WrEn<=0`; `Awr`/`Din` hold their previous values.
- Requester rules:
  - Hold `Req`/`WrAdr`/`WrData` stable until `Gnt` is seen.
  - Drop or replace the request on the edge that ends the `Gnt` cycle.
  - Dropping `Req` before grant is legal; no write results.
- Reset values: `Gnt0=Gnt1=0`, `WrEn=0`, `Awr=0`, `Din=0`, `Busy=1` with macro / 0 without, `cnt=1`, pointer=1.
- Reset mid-operation: `Reset_n` low clears all state and outputs immediately, whatever the state, including mid-CLEAR or with a grant outstanding. The in-flight write is lost, and the clear sequence restarts from R1 after release.

## Timing
- Grant latency: request sampled at edge N → `Gnt`/`WrEn` high in cycle N..N+1 → register file writes at edge N+1.
- Throughput:
  - Single active port: one write per 2 cycles.
  - Both ports continuously requesting: one write per cycle, alternating 0,1,0,1.
- CLEAR timing:
  - First clear write is presented after the first edge following `Reset_n` release.
  - 31 consecutive `WrEn` cycles for R1..R31.
  - `Busy` falls together with the R31 write presentation.
  - The first RUN grant can occur at the following edge.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `REGFILE_CLEAR_ON_RESET_EN` defined:
  - CLEAR state and `cnt` are built.
  - `Busy` resets to 1.
  - Every register R1..R31 reads 0 after the sequence completes.
- Not defined:
  - No CLEAR state; `Busy` is tied 0.
  - FSM resets straight into RUN; first grant is possible at the first edge after reset release.

## Test plan
- Reset release with macro → `WrEn=1` for exactly 31 cycles, `Awr`=1..31 in order, `Din=0`, `Busy` low from the R31 cycle; `Req0` held high throughout gets no `Gnt0` until the next edge.
- RUN, `Req0=1`, `WrAdr0=5`, `WrData0=0xDEADBEEF`, held → `Gnt0` pulses every other cycle, each pulse with `Awr=5`, `Din=0xDEADBEEF`, `WrEn=1`.
- Both ports request continuously (`WrAdr0=3`, `WrAdr1=4`) from reset → grants 0,1,0,1 on consecutive cycles, `Awr` alternating 3,4; no double grant.
- `Req1=1`, `WrAdr1=0`, `WrData1=0x1234` → `Gnt1` pulses, `WrEn=0`; subsequent register file read of R0 returns 0.
- `Reset_n` pulsed low at clear step `Awr=12` → all outputs 0 immediately; after release, sequence restarts at `Awr=1`.
- Without macro: `Req0=1` at the first edge after reset → `Gnt0=1`, `WrEn=1` in the next cycle, `Busy` constantly 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: two writeback requesters plus the register file write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Req0, Gnt0, Req1, Gnt1, WrEn, Busy;
  logic [ADDR_WIDTH-1:0] WrAdr0, WrAdr1, Awr;
  logic [DATA_WIDTH-1:0] WrData0, WrData1, Din;
  modport master (
    output Req0, WrAdr0, WrData0, Req1, WrAdr1, WrData1,
    input  Gnt0, Gnt1, Awr, Din, WrEn, Busy
  );
  modport slave (
    input  Req0, WrAdr0, WrData0, Req1, WrAdr1, WrData1,
    output Gnt0, Gnt1, Awr, Din, WrEn, Busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of one register file write port between two requesters.
// REGFILE_CLEAR_ON_RESET_EN adds a post-reset sequence writing zero to R1..R(2**ADDR_WIDTH-1).
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                     Clk,
  input logic                     Reset_n,
  regfile_write_arbiter_if.slave  bus
);
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d, wren_q, wren_d, ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] awr_q, awr_d, clr_adr;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  clearing, e0, e1, win0, win1;
`ifdef REGFILE_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, RUN} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      state_d = (cnt_q == '1) ? RUN : CLEAR;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + ADDR_WIDTH'(1);
    end
  end
  assign clearing = state_q == CLEAR;
  assign clr_adr  = cnt_q;
`else
  assign clearing = 1'b0;
  assign clr_adr  = '0;
`endif
  // A port that is holding Gnt this cycle is still updating its request, so it sits out one edge.
  assign e0   = bus.Req0 & ~gnt0_q;
  assign e1   = bus.Req1 & ~gnt1_q;
  assign win0 = ~clearing & e0 & (~e1 | ptr_q);
  assign win1 = ~clearing & e1 & (~e0 | ~ptr_q);
  always_comb begin
    gnt0_d = win0;
    gnt1_d = win1;
    awr_d  = clearing ? clr_adr : win0 ? bus.WrAdr0 : win1 ? bus.WrAdr1 : awr_q;
    din_d  = clearing ? '0 : win0 ? bus.WrData0 : win1 ? bus.WrData1 : din_q;
    wren_d = clearing | (win0 & |bus.WrAdr0) | (win1 & |bus.WrAdr1);
    ptr_d  = win0 ? 1'b0 : win1 ? 1'b1 : ptr_q;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      wren_q <= 1'b0;
      awr_q  <= '0;
      din_q  <= '0;
      ptr_q  <= 1'b1;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      wren_q <= wren_d;
      awr_q  <= awr_d;
      din_q  <= din_d;
      ptr_q  <= ptr_d;
    end
  assign bus.Gnt0 = gnt0_q;
  assign bus.Gnt1 = gnt1_q;
  assign bus.WrEn = wren_q;
  assign bus.Awr  = awr_q;
  assign bus.Din  = din_q;
  assign bus.Busy = clearing;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, R0 suppression, reset and the optional clear sequence.
module tb_regfile_write_arbiter;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic r0_hit = 1'b0;
  int   checks = 0;
  int   errors = 0;
`ifdef REGFILE_CLEAR_ON_RESET_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  regfile_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  // Register file model: only whether R0 ever receives a write matters here.
  always @(posedge Clk) if (bus.WrEn && bus.Awr == 5'd0) r0_hit <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.Req0 = 1'b0; bus.WrAdr0 = '0; bus.WrData0 = '0;
    bus.Req1 = 1'b0; bus.WrAdr1 = '0; bus.WrData1 = '0;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    Reset_n = 1'b1;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    repeat (31) step();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    step();
    check("rst_gnt0", 32'(bus.Gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.Gnt1), 32'd0);
    check("rst_wren", 32'(bus.WrEn), 32'd0);
    check("rst_awr", 32'(bus.Awr), 32'd0);
    check("rst_din", bus.Din, 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'(BUSY_RST));
`ifdef REGFILE_CLEAR_ON_RESET_EN
    Reset_n = 1'b1;
    bus.Req0 = 1'b1; bus.WrAdr0 = 5'd5; bus.WrData0 = 32'hDEADBEEF;
    for (int i = 1; i <= 31; i++) begin
      step();
      check("clr_wren", 32'(bus.WrEn), 32'd1);
      check("clr_awr", 32'(bus.Awr), 32'(i));
      check("clr_din", bus.Din, 32'd0);
      check("clr_gnt0", 32'(bus.Gnt0), 32'd0);
      check("clr_busy", 32'(bus.Busy), (i == 31) ? 32'd0 : 32'd1);
    end
    step();
    check("clr_first_gnt0", 32'(bus.Gnt0), 32'd1);
    check("clr_first_awr", 32'(bus.Awr), 32'd5);
    Reset_n = 1'b0;
    idle_inputs();
    step();
    Reset_n = 1'b1;
    repeat (12) step();
    check("mid_awr12", 32'(bus.Awr), 32'd12);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_awr", 32'(bus.Awr), 32'd0);
    check("mid_rst_wren", 32'(bus.WrEn), 32'd0);
    check("mid_rst_busy", 32'(bus.Busy), 32'd1);
    step();
    Reset_n = 1'b1;
    step();
    check("restart_awr", 32'(bus.Awr), 32'd1);
    check("restart_wren", 32'(bus.WrEn), 32'd1);
`endif
    do_reset();
    bus.Req0 = 1'b1; bus.WrAdr0 = 5'd5; bus.WrData0 = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("single_gnt0", 32'(bus.Gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("single_wren", 32'(bus.WrEn), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("single_awr", 32'(bus.Awr), 32'd5);
      check("single_din", bus.Din, 32'hDEADBEEF);
      check("single_gnt1", 32'(bus.Gnt1), 32'd0);
      check("single_busy", 32'(bus.Busy), 32'd0);
    end
    bus.Req0 = 1'b0;
    step();
    check("idle_wren", 32'(bus.WrEn), 32'd0);
    check("idle_gnt0", 32'(bus.Gnt0), 32'd0);
    check("idle_awr_hold", 32'(bus.Awr), 32'd5);
    check("idle_din_hold", bus.Din, 32'hDEADBEEF);
    bus.Req0 = 1'b1; bus.WrAdr0 = 5'd3; bus.WrData0 = 32'hA0A0A0A0;
    bus.Req1 = 1'b1; bus.WrAdr1 = 5'd4; bus.WrData1 = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ptr_gnt1", 32'(bus.Gnt1), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("ptr_gnt0", 32'(bus.Gnt0), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("ptr_awr", 32'(bus.Awr), (i % 2 == 0) ? 32'd4 : 32'd3);
    end
    do_reset();
    bus.Req0 = 1'b1; bus.WrAdr0 = 5'd3; bus.WrData0 = 32'hA0A0A0A0;
    bus.Req1 = 1'b1; bus.WrAdr1 = 5'd4; bus.WrData1 = 32'hB1B1B1B1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("both_gnt0", 32'(bus.Gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("both_gnt1", 32'(bus.Gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("both_awr", 32'(bus.Awr), (i % 2 == 0) ? 32'd3 : 32'd4);
      check("both_din", bus.Din, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      check("both_wren", 32'(bus.WrEn), 32'd1);
    end
    Reset_n = 1'b0;
    #1;
    check("async_gnt1", 32'(bus.Gnt1), 32'd0);
    check("async_wren", 32'(bus.WrEn), 32'd0);
    check("async_awr", 32'(bus.Awr), 32'd0);
    check("async_din", bus.Din, 32'd0);
    do_reset();
    bus.Req1 = 1'b1; bus.WrAdr1 = 5'd0; bus.WrData1 = 32'h1234;
    step();
    check("r0_gnt1", 32'(bus.Gnt1), 32'd1);
    check("r0_wren", 32'(bus.WrEn), 32'd0);
    check("r0_awr", 32'(bus.Awr), 32'd0);
    check("r0_din", bus.Din, 32'h1234);
    bus.Req1 = 1'b0;
    step();
    check("r0_gnt1_drop", 32'(bus.Gnt1), 32'd0);
    check("r0_read_zero", 32'(r0_hit), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
